// File: rtl/tick_sequencer.sv
// tick_sequencer: IDLE/RUN/FIN sequencer that issues count-enable pulses to an
// external 2-bit counter every PRESCALE+1 cycles and counts the wraps that
// counter reports through MAX, finishing after WRAPS wraps.
// Optional feature macro: TICK_SEQ_PAUSE_EN adds a PAUSE input that freezes
// the prescaler and suppresses EN while in RUN.
module tick_sequencer #(
    parameter int PS_W  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic             STOP,
    input  logic [PS_W-1:0]  PRESCALE,
    input  logic [CNT_W-1:0] WRAPS,
    input  logic             MAX,
    output logic             EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] WRAP_CNT
`ifdef TICK_SEQ_PAUSE_EN
    ,
    input  logic             PAUSE
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
    logic [PS_W-1:0]   ps_lat_q, ps_lat_d;
    logic [CNT_W-1:0]  wraps_lat_q, wraps_lat_d;
    logic [CNT_W-1:0]  wrap_cnt_q, wrap_cnt_d;

    logic              ps_hit;
    logic              paused;
    logic              en_int;
    logic [CNT_W-1:0]  wrap_inc;

`ifdef TICK_SEQ_PAUSE_EN
    assign paused = PAUSE;
`else
    assign paused = 1'b0;
`endif

    // Prescaler terminal count is decoded purely from registered state.
    assign ps_hit   = (state_q == RUN) && (ps_cnt_q == ps_lat_q);
    assign en_int   = ps_hit && !paused;
    assign wrap_inc = wrap_cnt_q + CNT_W'(1);

    assign EN       = en_int;
    assign BUSY     = (state_q == RUN);
    assign DONE     = (state_q == FIN);
    assign WRAP_CNT = wrap_cnt_q;

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ps_cnt_q    <= '0;
            ps_lat_q    <= '0;
            wraps_lat_q <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ps_cnt_q    <= ps_cnt_d;
            ps_lat_q    <= ps_lat_d;
            wraps_lat_q <= wraps_lat_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        ps_cnt_d    = ps_cnt_q;
        ps_lat_d    = ps_lat_q;
        wraps_lat_d = wraps_lat_q;
        wrap_cnt_d  = wrap_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    ps_lat_d    = PRESCALE;
                    wraps_lat_d = WRAPS;
                    wrap_cnt_d  = '0;
                    ps_cnt_d    = '0;
                    state_d     = (WRAPS == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (STOP) begin
                    // Abort wins over a same-cycle wrap; that wrap is dropped.
                    state_d = IDLE;
                end else if (!paused) begin
                    ps_cnt_d = ps_hit ? '0 : ps_cnt_q + PS_W'(1);
                    if (en_int && MAX && (wrap_cnt_q != wraps_lat_q)) begin
                        wrap_cnt_d = wrap_inc;
                        if (wrap_inc == wraps_lat_q) begin
                            state_d = FIN;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
